// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data memory access unit with ready/rvalid bus handshake
//
// Ports:
//   clk, resetn                     clock, asynchronous active-low reset
//   valid_in, mem_read_in,          EX/MEM instruction qualifiers
//   mem_write_in, funct3_in
//   addr_in, store_data_in          byte address and rs2 store value
//   dmem_req, dmem_we, dmem_addr,   bus request side (held stable while in REQ)
//   dmem_wstrb, dmem_wdata
//   dmem_ready, dmem_rvalid,        bus response side
//   dmem_rdata
//   load_data_out                   extracted/extended load result, held until next load
//   stall_out                       freeze upstream pipeline registers
//   misaligned_out                  misaligned access flagged, no bus access made
module mem_access_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data_out,
    output logic        stall_out,
    output logic        misaligned_out
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [29:0] addr_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic [31:0] load_q;

    logic        is_byte, is_half;
    logic        access, misaligned, start;
    logic [3:0]  wstrb_in;
    logic [31:0] wdata_in;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    // funct3[1:0] alone fixes the size; the reserved encodings (011,110,111)
    // fall through to word access.
    always_comb begin
        is_byte    = (funct3_in[1:0] == 2'b00);
        is_half    = (funct3_in[1:0] == 2'b01);
        access     = mem_read_in | mem_write_in;
        misaligned = (is_half & addr_in[0]) |
                     (~is_byte & ~is_half & (addr_in[1:0] != 2'b00));
        // Gated with resetn so the pipeline is never stalled while held in reset.
        start          = resetn & (state_q == IDLE) & valid_in & access & ~misaligned;
        misaligned_out = resetn & (state_q == IDLE) & valid_in & access & misaligned;
    end

    always_comb begin
        wstrb_in = 4'b1111;
        wdata_in = store_data_in;
        if (is_byte) begin
            wstrb_in = 4'b0001 << addr_in[1:0];
            wdata_in = {4{store_data_in[7:0]}};
        end else if (is_half) begin
            wstrb_in = addr_in[1] ? 4'b1100 : 4'b0011;
            wdata_in = {2{store_data_in[15:0]}};
        end
    end

    always_comb begin
        case (off_q)
            2'd0:    byte_sel = dmem_rdata[7:0];
            2'd1:    byte_sel = dmem_rdata[15:8];
            2'd2:    byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = REQ;
            REQ:     if (dmem_ready) state_d = we_q ? DONE : WAIT;
            WAIT:    if (dmem_rvalid) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request fields are captured once at start and only change on the next
    // start, which keeps them stable across any number of REQ wait cycles.
    // Loads drive no strobes or data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q   <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            off_q    <= '0;
            wstrb_q  <= '0;
            wdata_q  <= '0;
        end else if (start) begin
            addr_q   <= addr_in[31:2];
            we_q     <= mem_write_in;
            funct3_q <= funct3_in;
            off_q    <= addr_in[1:0];
            wstrb_q  <= mem_write_in ? wstrb_in : 4'b0000;
            wdata_q  <= mem_write_in ? wdata_in : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            load_q <= '0;
        end else if ((state_q == WAIT) && dmem_rvalid) begin
            load_q <= load_ext;
        end
    end

    always_comb begin
        dmem_req      = (state_q == REQ);
        dmem_we       = we_q;
        dmem_addr     = {addr_q, 2'b00};
        dmem_wstrb    = wstrb_q;
        dmem_wdata    = wdata_q;
        load_data_out = load_q;
        stall_out     = start | (state_q == REQ) | (state_q == WAIT);
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed scoreboard testbench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid_in, mem_read_in, mem_write_in;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in, store_data_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] load_data_out;
    logic        stall_out, misaligned_out;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_ld = 32'd0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk            (clk),
        .resetn         (resetn),
        .valid_in       (valid_in),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .funct3_in      (funct3_in),
        .addr_in        (addr_in),
        .store_data_in  (store_data_in),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_wdata     (dmem_wdata),
        .dmem_ready     (dmem_ready),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
        .load_data_out  (load_data_out),
        .stall_out      (stall_out),
        .misaligned_out (misaligned_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " dmem_req"},   {31'd0, dmem_req},   32'd0);
        check({tag, " dmem_we"},    {31'd0, dmem_we},    32'd0);
        check({tag, " dmem_addr"},  dmem_addr,           32'd0);
        check({tag, " dmem_wstrb"}, {28'd0, dmem_wstrb}, 32'd0);
        check({tag, " dmem_wdata"}, dmem_wdata,          32'd0);
        check({tag, " load_data"},  load_data_out,       32'd0);
        check({tag, " stall"},      {31'd0, stall_out},  32'd0);
    endtask

    // One instruction held in EX/MEM until the unit releases the stall.
    // rdy_d / rv_d: cycle (1-based) within REQ / WAIT where ready / rvalid rise.
    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                          input int rdy_d, input int rv_d, input int exp_stall,
                          input logic exp_mis, input logic [31:0] exp_addr,
                          input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_ld);
        int   cyc = 0;
        int   stalls = 0;
        int   rc = 0;
        int   wc = 0;
        logic accepted = 1'b0;
        logic got_rv = 1'b0;
        logic done = 1'b0;
        @(negedge clk);
        valid_in      = 1'b1;
        mem_write_in  = we;
        mem_read_in   = ~we;
        funct3_in     = f3;
        addr_in       = a;
        store_data_in = sd;
        dmem_rdata    = rd;
        if (!we && !exp_mis) exp_q.push_back(exp_ld);
        while (!done && cyc < 40) begin
            if (cyc > 0) @(negedge clk);
            dmem_ready  = 1'b0;
            dmem_rvalid = 1'b0;
            if (dmem_req) begin
                rc++;
                check({tag, " addr"},  dmem_addr,           exp_addr);
                check({tag, " we"},    {31'd0, dmem_we},    {31'd0, we});
                check({tag, " wstrb"}, {28'd0, dmem_wstrb}, {28'd0, exp_wstrb});
                check({tag, " wdata"}, dmem_wdata,          exp_wdata);
                if (rc >= rdy_d) begin
                    dmem_ready = 1'b1;
                    accepted   = 1'b1;
                end
            end else if (accepted && !we && !got_rv) begin
                wc++;
                if (wc >= rv_d) begin
                    dmem_rvalid = 1'b1;
                    got_rv      = 1'b1;
                end
            end
            #1;
            if (cyc == 0) check({tag, " misaligned"}, {31'd0, misaligned_out}, {31'd0, exp_mis});
            if (stall_out) stalls++;
            else done = 1'b1;
            cyc++;
        end
        check({tag, " timeout"}, {31'd0, done}, 32'd1);
        check({tag, " stall cycles"}, stalls, exp_stall);
        if (exp_mis) begin
            check({tag, " req count"}, rc, 0);
            @(negedge clk);
            #1;
            check({tag, " req held low"}, {31'd0, dmem_req}, 32'd0);
            check({tag, " misaligned held"}, {31'd0, misaligned_out}, 32'd1);
            check({tag, " no stall"}, {31'd0, stall_out}, 32'd0);
        end else if (!we) begin
            if (exp_q.size() == 0) begin
                check({tag, " scoreboard empty"}, 32'd1, 32'd0);
            end else begin
                last_ld = exp_q.pop_front();
                check({tag, " load_data"}, load_data_out, last_ld);
            end
        end else begin
            check({tag, " load_data kept"}, load_data_out, last_ld);
        end
        valid_in     = 1'b0;
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        dmem_ready   = 1'b0;
        dmem_rvalid  = 1'b0;
    endtask

    initial begin
        resetn        = 1'b0;
        valid_in      = 1'b0;
        mem_read_in   = 1'b0;
        mem_write_in  = 1'b0;
        funct3_in     = 3'b000;
        addr_in       = 32'd0;
        store_data_in = 32'd0;
        dmem_ready    = 1'b0;
        dmem_rvalid   = 1'b0;
        dmem_rdata    = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        check("reset misaligned", {31'd0, misaligned_out}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        //     tag     we    f3      addr          store         rdata        rdy rv stall mis  exp_addr      wstrb    wdata         load
        access("LB",   1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF1234, 1, 1, 3, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FF80);
        access("SH",   1'b1, 3'b001, 32'h0000_0202, 32'h0000BEEF, 32'h0,        1, 1, 2, 1'b0, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        access("LWmis",1'b0, 3'b010, 32'h0000_0301, 32'h0,        32'h0,        1, 1, 0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0);
        access("LHU",  1'b0, 3'b101, 32'h0000_0402, 32'h0,        32'hABCD0000, 3, 2, 6, 1'b0, 32'h0000_0400, 4'b0000, 32'h0,        32'h0000_ABCD);
        access("SB",   1'b1, 3'b000, 32'h0000_0601, 32'h123456A5, 32'h0,        1, 1, 2, 1'b0, 32'h0000_0600, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        access("SW",   1'b1, 3'b010, 32'h0000_0700, 32'hCAFEF00D, 32'h0,        2, 1, 3, 1'b0, 32'h0000_0700, 4'b1111, 32'hCAFE_F00D, 32'h0);
        access("LH",   1'b0, 3'b001, 32'h0000_0802, 32'h0,        32'h80017FFF, 1, 1, 3, 1'b0, 32'h0000_0800, 4'b0000, 32'h0,        32'hFFFF_8001);
        access("LBU",  1'b0, 3'b100, 32'h0000_0901, 32'h0,        32'h12349A78, 1, 3, 5, 1'b0, 32'h0000_0900, 4'b0000, 32'h0,        32'h0000_009A);
        access("L011", 1'b0, 3'b011, 32'h0000_0A00, 32'h0,        32'h13572468, 1, 1, 3, 1'b0, 32'h0000_0A00, 4'b0000, 32'h0,        32'h1357_2468);
        access("SHmis",1'b1, 3'b001, 32'h0000_0B01, 32'h0000FFFF, 32'h0,        1, 1, 0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0);

        // Reset while a load sits in WAIT: everything clears at once and the
        // late rvalid must not produce a completion.
        @(negedge clk);
        valid_in    = 1'b1;
        mem_read_in = 1'b1;
        funct3_in   = 3'b010;
        addr_in     = 32'h0000_0500;
        dmem_rdata  = 32'h5555_AAAA;
        @(negedge clk);
        check("rst-wait req", {31'd0, dmem_req}, 32'd1);
        dmem_ready = 1'b1;
        @(negedge clk);
        dmem_ready = 1'b0;
        #1;
        check("rst-wait in WAIT", {30'd0, stall_out, dmem_req}, 32'd2);
        #1;
        resetn = 1'b0;
        #1;
        check_all_zero("rst-wait");
        valid_in    = 1'b0;
        mem_read_in = 1'b0;
        last_ld     = 32'd0;
        @(negedge clk);
        resetn      = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        check("late rvalid load_data", load_data_out, 32'd0);
        check("late rvalid stall", {31'd0, stall_out}, 32'd0);

        access("LWpost",1'b0, 3'b010, 32'h0000_0C04, 32'h0,       32'h0BADF00D, 1, 1, 3, 1'b0, 32'h0000_0C04, 4'b0000, 32'h0,        32'h0BAD_F00D);

        check("scoreboard drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
